change_dispenser: RTL

//  Downstream stage of the vending controller. Consumes the registered MO (change/refund value)
//  and PO (product select) outputs of the controller.

---
 rtl/change_dispenser.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin ejector (largest coin first) plus a product motor
// pulse driver with a one-entry pending slot.
`default_nettype none

module change_dispenser #(
  parameter int         COIN_GAP  = 1,
  parameter int         MOTOR_CYC = 4,
  parameter logic [7:0] V0        = 8'd50,
  parameter logic [7:0] V1        = 8'd10,
  parameter logic [7:0] V2        = 8'd5,
  parameter logic [7:0] V3        = 8'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  MO,
  input  logic [1:0]  PO,
  output logic [1:0]  coin_type,
  output logic        coin_vld,
  output logic [2:0]  motor,
  output logic        busy,
  output logic        ovf,
  output logic [15:0] paid_total
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LOAD   = 4'((COIN_GAP > 0) ? COIN_GAP - 1 : 0);
  localparam logic [3:0] MOTOR_LOAD = 4'(MOTOR_CYC);

  state_t      state, state_nx;
  logic [7:0]  rem, rem_nx;
  logic [3:0]  gap_cnt, gap_cnt_nx;
  logic [1:0]  coin_type_nx;
  logic        coin_vld_nx;
  logic [15:0] paid_nx;
  logic        ovf_nx;
  logic        busy_nx;
  logic [2:0]  motor_nx;
  logic [3:0]  mcnt, mcnt_nx;
  logic        pend_vld, pend_vld_nx;
  logic [1:0]  pend_po, pend_po_nx;

  logic [1:0]  sel_type;
  logic [7:0]  sel_val;
  logic [8:0]  sum;
  logic [7:0]  sat;

  function automatic logic [2:0] onehot(input logic [1:0] p);
    case (p)
      2'd1:    onehot = 3'b001;
      2'd2:    onehot = 3'b010;
      2'd3:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  always_comb begin
    sel_type = 2'd3;
    sel_val  = V3;
    if (rem >= V0) begin
      sel_type = 2'd0;
      sel_val  = V0;
    end else if (rem >= V1) begin
      sel_type = 2'd1;
      sel_val  = V1;
    end else if (rem >= V2) begin
      sel_type = 2'd2;
      sel_val  = V2;
    end
  end

  // New change is added and clamped before the current coin is subtracted.
  assign sum = {1'b0, rem} + {1'b0, MO};
  assign sat = sum[8] ? 8'hFF : sum[7:0];

  always_comb begin
    state_nx     = state;
    rem_nx       = rem;
    gap_cnt_nx   = gap_cnt;
    coin_type_nx = coin_type;
    coin_vld_nx  = 1'b0;
    paid_nx      = paid_total;
    ovf_nx       = ovf | sum[8];
    motor_nx     = motor;
    mcnt_nx      = mcnt;
    pend_vld_nx  = pend_vld;
    pend_po_nx   = pend_po;

    case (state)
      IDLE: begin
        rem_nx = sat;
        if (MO != 8'd0) state_nx = EMIT;
      end
      EMIT: begin
        rem_nx       = sat - sel_val;
        coin_type_nx = sel_type;
        coin_vld_nx  = 1'b1;
        paid_nx      = paid_total + {8'd0, sel_val};
        if (rem_nx == 8'd0) begin
          state_nx = IDLE;
        end else if (COIN_GAP > 0) begin
          state_nx   = GAP;
          gap_cnt_nx = GAP_LOAD;
        end else begin
          state_nx = EMIT;
        end
      end
      GAP: begin
        rem_nx = sat;
        if (gap_cnt == 4'd0) state_nx = EMIT;
        else gap_cnt_nx = gap_cnt - 4'd1;
      end
      default: state_nx = IDLE;
    endcase

    if (motor == 3'b000) begin
      if (PO != 2'd0) begin
        motor_nx = onehot(PO);
        mcnt_nx  = MOTOR_LOAD;
      end
    end else begin
      mcnt_nx = mcnt - 4'd1;
      if (mcnt == 4'd1) begin
        // Pulse ends: hand over to the pending item (or a fresh request) with no gap.
        if (pend_vld) begin
          motor_nx    = onehot(pend_po);
          mcnt_nx     = MOTOR_LOAD;
          pend_vld_nx = (PO != 2'd0);
          pend_po_nx  = PO;
        end else if (PO != 2'd0) begin
          motor_nx = onehot(PO);
          mcnt_nx  = MOTOR_LOAD;
        end else begin
          motor_nx = 3'b000;
        end
      end else if (PO != 2'd0) begin
        if (!pend_vld) begin
          pend_vld_nx = 1'b1;
          pend_po_nx  = PO;
        end else begin
          ovf_nx = 1'b1;
        end
      end
    end

    busy_nx = (state_nx != IDLE) | (motor_nx != 3'b000) | pend_vld_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= 8'd0;
      gap_cnt    <= 4'd0;
      coin_type  <= 2'd0;
      coin_vld   <= 1'b0;
      paid_total <= 16'd0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
      motor      <= 3'b000;
      mcnt       <= 4'd0;
      pend_vld   <= 1'b0;
      pend_po    <= 2'd0;
    end else begin
      state      <= state_nx;
      rem        <= rem_nx;
      gap_cnt    <= gap_cnt_nx;
      coin_type  <= coin_type_nx;
      coin_vld   <= coin_vld_nx;
      paid_total <= paid_nx;
      ovf        <= ovf_nx;
      busy       <= busy_nx;
      motor      <= motor_nx;
      mcnt       <= mcnt_nx;
      pend_vld   <= pend_vld_nx;
      pend_po    <= pend_po_nx;
    end
  end

endmodule

`default_nettype wire
